// File: rtl/pcie_fifo_pkg.sv
// Shared helpers and types for the width-converting PCIe prefetch FIFO.
// Gearbox mode and lane ratio are resolved from the port widths at elaboration.
package pcie_fifo_pkg;

    typedef enum logic [1:0] {GB_UP, GB_DOWN, GB_PASS} gb_mode_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int wide_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int ratio(input int a, input int b);
        return (a > b) ? (a / b) : (b / a);
    endfunction

    function automatic gb_mode_t gb_mode(input int wr_w, input int rd_w);
        if (wr_w < rd_w) return GB_UP;
        if (wr_w > rd_w) return GB_DOWN;
        return GB_PASS;
    endfunction

endpackage

// File: rtl/pcie_fifo_ram.sv
// Simple dual-port storage for the gearbox FIFO: synchronous write, asynchronous read.
module pcie_fifo_ram
    import pcie_fifo_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [1 << AW];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pcie_fifo_gearbox.sv
// Width-converting FWFT prefetch FIFO (pack, unpack or 1:1) for the PCIe DMA datapath.
// Optional `PCIE_FIFO_LEVEL_EN adds registered rd_level / wr_afull outputs.
module pcie_fifo_gearbox
    import pcie_fifo_pkg::*;
#(
    parameter int WR_DATA_WIDTH = 16,
    parameter int RD_DATA_WIDTH = 128,
    parameter int DEPTH_WIDTH   = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef PCIE_FIFO_LEVEL_EN
    output logic [DEPTH_WIDTH+1:0]   rd_level,
    output logic                     wr_afull,
`endif
    input  logic                     wr_en,
    output logic                     wr_vld,
    input  logic [WR_DATA_WIDTH-1:0] wr_data,
    input  logic                     rd_en,
    output logic                     rd_vld,
    output logic [RD_DATA_WIDTH-1:0] rd_data
);

    localparam int       WIDE_W   = wide_w(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int       RATIO    = ratio(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam gb_mode_t MODE     = gb_mode(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int       WR_LANES = (MODE == GB_UP)   ? RATIO : 1;
    localparam int       RD_LANES = (MODE == GB_DOWN) ? RATIO : 1;
    localparam int       IDX_W    = (RATIO > 1) ? clog2(RATIO) : 1;
    localparam int       DEPTH    = 1 << DEPTH_WIDTH;
    localparam int       CNT_W    = DEPTH_WIDTH + 1;

    logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       ram_cnt_q, ram_cnt_d;
    logic [IDX_W-1:0]       wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [WIDE_W-1:0]      acc_q, acc_d, out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   rdy_q, rdy_d;

    logic [WIDE_W-1:0]      acc_ins, ram_rdata;
    logic                   wr_acc, pop, commit, pop_last, load;

    // Write side is blocked purely on the registered count; a same-cycle read never frees space early.
    assign wr_vld  = rst_n && rdy_q && (ram_cnt_q < CNT_W'(DEPTH));
    assign rd_vld  = rst_n && out_valid_q;
    assign rd_data = rst_n ? out_data_q[rd_idx_q*RD_DATA_WIDTH +: RD_DATA_WIDTH] : '0;

    always_comb begin
        wr_acc   = wr_en && wr_vld;
        pop      = rd_en && rd_vld;
        acc_ins  = acc_q;
        acc_ins[wr_idx_q*WR_DATA_WIDTH +: WR_DATA_WIDTH] = wr_data;
        commit   = wr_acc && (wr_idx_q == IDX_W'(WR_LANES - 1));
        pop_last = pop && (rd_idx_q == IDX_W'(RD_LANES - 1));
        load     = (ram_cnt_q != '0) && (!out_valid_q || pop_last);
    end

    always_comb begin
        rdy_d       = 1'b1;
        wr_idx_d    = wr_idx_q;
        acc_d       = acc_q;
        rd_idx_d    = rd_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ram_cnt_d   = ram_cnt_q;
        wr_ptr_d    = wr_ptr_q + DEPTH_WIDTH'(commit);
        rd_ptr_d    = rd_ptr_q + DEPTH_WIDTH'(load);

        if (wr_acc) begin
            acc_d    = acc_ins;
            wr_idx_d = commit ? '0 : wr_idx_q + IDX_W'(1);
        end

        if (pop) rd_idx_d = pop_last ? '0 : rd_idx_q + IDX_W'(1);

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = ram_rdata;
        end else if (pop_last) begin
            out_valid_d = 1'b0;
        end

        case ({commit, load})
            2'b10:   ram_cnt_d = ram_cnt_q + CNT_W'(1);
            2'b01:   ram_cnt_d = ram_cnt_q - CNT_W'(1);
            default: ram_cnt_d = ram_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            rdy_q       <= rdy_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef PCIE_FIFO_LEVEL_EN
    localparam int LVL_W = DEPTH_WIDTH + 2;

    logic [LVL_W-1:0] rd_level_q, rd_level_d;
    logic             wr_afull_q, wr_afull_d;

    always_comb begin
        rd_level_d = LVL_W'(ram_cnt_d) + LVL_W'(out_valid_d);
        wr_afull_d = (ram_cnt_d >= CNT_W'(DEPTH - 2));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_level_q <= '0;
            wr_afull_q <= 1'b0;
        end else begin
            rd_level_q <= rd_level_d;
            wr_afull_q <= wr_afull_d;
        end
    end

    assign rd_level = rd_level_q;
    assign wr_afull = wr_afull_q;
`endif

    pcie_fifo_ram #(
        .WIDTH (WIDE_W),
        .AW    (DEPTH_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (commit),
        .waddr (wr_ptr_q),
        .wdata (acc_ins),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_pcie_fifo_gearbox.sv
// Self-checking bench for pcie_fifo_gearbox: pack, unpack, full, reset, simultaneous and ratio-1 cases.
module tb_pcie_fifo_gearbox;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // 16 -> 128, DEPTH_WIDTH 9
    logic         u_wr_en, u_rd_en, u_wr_vld, u_rd_vld;
    logic [15:0]  u_wr_data;
    logic [127:0] u_rd_data;
    // 128 -> 16, DEPTH_WIDTH 4
    logic         d_wr_en, d_rd_en, d_wr_vld, d_rd_vld;
    logic [127:0] d_wr_data;
    logic [15:0]  d_rd_data;
    // 16 -> 128, DEPTH_WIDTH 2
    logic         f_wr_en, f_rd_en, f_wr_vld, f_rd_vld;
    logic [15:0]  f_wr_data;
    logic [127:0] f_rd_data;
    // 32 -> 32, DEPTH_WIDTH 3
    logic         p_wr_en, p_rd_en, p_wr_vld, p_rd_vld;
    logic [31:0]  p_wr_data, p_rd_data;
`ifdef PCIE_FIFO_LEVEL_EN
    logic [10:0]  u_rd_level;
    logic [5:0]   d_rd_level;
    logic [3:0]   f_rd_level;
    logic [4:0]   p_rd_level;
    logic         u_wr_afull, d_wr_afull, f_wr_afull, p_wr_afull;
`endif

    pcie_fifo_gearbox #(.WR_DATA_WIDTH(16), .RD_DATA_WIDTH(128), .DEPTH_WIDTH(9)) u_up (
        .clk(clk), .rst_n(rst_n),
`ifdef PCIE_FIFO_LEVEL_EN
        .rd_level(u_rd_level), .wr_afull(u_wr_afull),
`endif
        .wr_en(u_wr_en), .wr_vld(u_wr_vld), .wr_data(u_wr_data),
        .rd_en(u_rd_en), .rd_vld(u_rd_vld), .rd_data(u_rd_data));

    pcie_fifo_gearbox #(.WR_DATA_WIDTH(128), .RD_DATA_WIDTH(16), .DEPTH_WIDTH(4)) u_dn (
        .clk(clk), .rst_n(rst_n),
`ifdef PCIE_FIFO_LEVEL_EN
        .rd_level(d_rd_level), .wr_afull(d_wr_afull),
`endif
        .wr_en(d_wr_en), .wr_vld(d_wr_vld), .wr_data(d_wr_data),
        .rd_en(d_rd_en), .rd_vld(d_rd_vld), .rd_data(d_rd_data));

    pcie_fifo_gearbox #(.WR_DATA_WIDTH(16), .RD_DATA_WIDTH(128), .DEPTH_WIDTH(2)) u_fl (
        .clk(clk), .rst_n(rst_n),
`ifdef PCIE_FIFO_LEVEL_EN
        .rd_level(f_rd_level), .wr_afull(f_wr_afull),
`endif
        .wr_en(f_wr_en), .wr_vld(f_wr_vld), .wr_data(f_wr_data),
        .rd_en(f_rd_en), .rd_vld(f_rd_vld), .rd_data(f_rd_data));

    pcie_fifo_gearbox #(.WR_DATA_WIDTH(32), .RD_DATA_WIDTH(32), .DEPTH_WIDTH(3)) u_ps (
        .clk(clk), .rst_n(rst_n),
`ifdef PCIE_FIFO_LEVEL_EN
        .rd_level(p_rd_level), .wr_afull(p_wr_afull),
`endif
        .wr_en(p_wr_en), .wr_vld(p_wr_vld), .wr_data(p_wr_data),
        .rd_en(p_rd_en), .rd_vld(p_rd_vld), .rd_data(p_rd_data));

    task automatic test_reset();
        rst_n = 1'b0;
        u_wr_en = 0; u_rd_en = 0; u_wr_data = '0;
        d_wr_en = 0; d_rd_en = 0; d_wr_data = '0;
        f_wr_en = 0; f_rd_en = 0; f_wr_data = '0;
        p_wr_en = 0; p_rd_en = 0; p_wr_data = '0;
        repeat (3) @(negedge clk);
        checks++; if (u_wr_vld !== 1'b0) begin errors++; $display("FAIL reset_wr_vld got %b exp 0", u_wr_vld); end
        checks++; if (u_rd_vld !== 1'b0) begin errors++; $display("FAIL reset_rd_vld got %b exp 0", u_rd_vld); end
        checks++; if (u_rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", u_rd_data); end
        checks++; if (d_rd_data !== '0) begin errors++; $display("FAIL reset_dn_rd_data got %h exp 0", d_rd_data); end
`ifdef PCIE_FIFO_LEVEL_EN
        checks++; if (p_rd_level !== '0) begin errors++; $display("FAIL reset_rd_level got %0d exp 0", p_rd_level); end
        checks++; if (p_wr_afull !== 1'b0) begin errors++; $display("FAIL reset_wr_afull got %b exp 0", p_wr_afull); end
`endif
        rst_n = 1'b1;
        checks++; if (u_wr_vld !== 1'b0) begin errors++; $display("FAIL release_pre_edge_wr_vld got %b exp 0", u_wr_vld); end
        @(negedge clk);
        checks++; if (u_wr_vld !== 1'b1) begin errors++; $display("FAIL release_wr_vld got %b exp 1", u_wr_vld); end
        checks++; if (d_wr_vld !== 1'b1) begin errors++; $display("FAIL release_dn_wr_vld got %b exp 1", d_wr_vld); end
        checks++; if (f_wr_vld !== 1'b1) begin errors++; $display("FAIL release_fl_wr_vld got %b exp 1", f_wr_vld); end
        checks++; if (p_rd_vld !== 1'b0) begin errors++; $display("FAIL release_rd_vld got %b exp 0", p_rd_vld); end
    endtask

    task automatic test_pack();
        logic [127:0] exp;
        for (int i = 0; i < 8; i++) begin
            u_wr_en = 1; u_wr_data = 16'(i + 1);
            exp[i*16 +: 16] = 16'(i + 1);
            checks++; if (u_wr_vld !== 1'b1) begin errors++; $display("FAIL pack_wr_vld lane %0d got %b exp 1", i, u_wr_vld); end
            @(negedge clk);
        end
        u_wr_en = 0;
        checks++; if (u_rd_vld !== 1'b0) begin errors++; $display("FAIL pack_latency_E got %b exp 0", u_rd_vld); end
        @(negedge clk);
        checks++; if (u_rd_vld !== 1'b1) begin errors++; $display("FAIL pack_latency_E1 got %b exp 1", u_rd_vld); end
        checks++; if (u_rd_data !== exp) begin errors++; $display("FAIL pack_data got %h exp %h", u_rd_data, exp); end
        u_rd_en = 1;
        @(negedge clk);
        u_rd_en = 0;
        checks++; if (u_rd_vld !== 1'b0) begin errors++; $display("FAIL pack_after_pop got %b exp 0", u_rd_vld); end
    endtask

    task automatic test_unpack();
        logic [127:0] w1, w2;
        logic [15:0]  exp;
        for (int j = 0; j < 8; j++) begin
            w1[j*16 +: 16] = 16'(j + 1);
            w2[j*16 +: 16] = 16'(j + 16'h11);
        end
        d_wr_en = 1; d_wr_data = w1;
        @(negedge clk);
        d_wr_data = w2;
        @(negedge clk);
        d_wr_en = 0;
        checks++; if (d_rd_vld !== 1'b1) begin errors++; $display("FAIL unpack_first_vld got %b exp 1", d_rd_vld); end
        d_rd_en = 1;
        for (int k = 0; k < 16; k++) begin
            exp = (k < 8) ? 16'(k + 1) : 16'(k - 8 + 16'h11);
            checks++; if (d_rd_vld !== 1'b1) begin errors++; $display("FAIL unpack_bubble lane %0d got %b exp 1", k, d_rd_vld); end
            checks++; if (d_rd_data !== exp) begin errors++; $display("FAIL unpack_data lane %0d got %h exp %h", k, d_rd_data, exp); end
            @(negedge clk);
        end
        d_rd_en = 0;
        checks++; if (d_rd_vld !== 1'b0) begin errors++; $display("FAIL unpack_empty got %b exp 0", d_rd_vld); end
    endtask

    task automatic test_full();
        logic [15:0]  q[$];
        logic [127:0] exp;
        int accepted = 0;
        int at_block = -1;
        f_wr_en = 1;
        for (int n = 0; n < 48; n++) begin
            f_wr_data = 16'(16'h3000 + n);
            if (f_wr_vld) begin
                q.push_back(f_wr_data);
                accepted++;
            end else if (at_block < 0) begin
                at_block = accepted;
            end
            @(negedge clk);
        end
        f_wr_en = 0;
        checks++; if (at_block !== 40) begin errors++; $display("FAIL full_block_point got %0d exp 40", at_block); end
        checks++; if (accepted !== 40) begin errors++; $display("FAIL full_accepted got %0d exp 40", accepted); end
        checks++; if (f_wr_vld !== 1'b0) begin errors++; $display("FAIL full_wr_vld got %b exp 0", f_wr_vld); end
        f_rd_en = 1;
        checks++; if (f_rd_vld !== 1'b1) begin errors++; $display("FAIL full_rd_vld got %b exp 1", f_rd_vld); end
        @(negedge clk);
        f_rd_en = 0;
        checks++; if (f_wr_vld !== 1'b1) begin errors++; $display("FAIL full_after_pop_wr_vld got %b exp 1", f_wr_vld); end
        for (int j = 0; j < 8; j++) exp[j*16 +: 16] = q[j];
        repeat (8) void'(q.pop_front());
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            f_rd_en = f_rd_vld;
            if (f_rd_vld) begin
                for (int j = 0; j < 8; j++) exp[j*16 +: 16] = q[j];
                repeat (8) void'(q.pop_front());
                checks++; if (f_rd_data !== exp) begin errors++; $display("FAIL full_drain_data got %h exp %h", f_rd_data, exp); end
            end
            @(negedge clk);
        end
        f_rd_en = 0;
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL full_drain_left got %0d exp 0", q.size()); end
    endtask

    task automatic test_reset_mid_pack();
        logic [127:0] exp;
        for (int i = 0; i < 3; i++) begin
            u_wr_en = 1; u_wr_data = 16'(16'h0055 + i);
            @(negedge clk);
        end
        u_wr_en = 0; rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            u_wr_en = 1; u_wr_data = 16'(16'h00A1 + i);
            exp[i*16 +: 16] = 16'(16'h00A1 + i);
            @(negedge clk);
        end
        u_wr_en = 0;
        @(negedge clk);
        checks++; if (u_rd_vld !== 1'b1) begin errors++; $display("FAIL midreset_vld got %b exp 1", u_rd_vld); end
        checks++; if (u_rd_data !== exp) begin errors++; $display("FAIL midreset_data got %h exp %h", u_rd_data, exp); end
        u_rd_en = 1;
        @(negedge clk);
        u_rd_en = 0;
        checks++; if (u_rd_vld !== 1'b0) begin errors++; $display("FAIL midreset_extra got %b exp 0", u_rd_vld); end
    endtask

    task automatic test_simultaneous();
        logic [15:0]  q[$];
        logic [127:0] exp;
        for (int n = 0; n < 31; n++) begin
            f_wr_en = 1; f_wr_data = 16'(16'h5000 + n);
            if (f_wr_vld) q.push_back(f_wr_data);
            @(negedge clk);
            if (n == 23) begin
                checks++; if (u_fl.ram_cnt_q !== 3'd2) begin errors++; $display("FAIL simul_pre_cnt got %0d exp 2", u_fl.ram_cnt_q); end
            end
        end
        f_wr_data = 16'h50FF;
        f_rd_en = 1;
        if (f_wr_vld) q.push_back(f_wr_data);
        checks++; if (f_rd_vld !== 1'b1) begin errors++; $display("FAIL simul_rd_vld got %b exp 1", f_rd_vld); end
        for (int j = 0; j < 8; j++) exp[j*16 +: 16] = q[j];
        repeat (8) void'(q.pop_front());
        checks++; if (f_rd_data !== exp) begin errors++; $display("FAIL simul_data got %h exp %h", f_rd_data, exp); end
        @(negedge clk);
        f_wr_en = 0; f_rd_en = 0;
        checks++; if (u_fl.ram_cnt_q !== 3'd2) begin errors++; $display("FAIL simul_cnt got %0d exp 2", u_fl.ram_cnt_q); end
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            f_rd_en = f_rd_vld;
            if (f_rd_vld) begin
                for (int j = 0; j < 8; j++) exp[j*16 +: 16] = q[j];
                repeat (8) void'(q.pop_front());
                checks++; if (f_rd_data !== exp) begin errors++; $display("FAIL simul_drain got %h exp %h", f_rd_data, exp); end
            end
            @(negedge clk);
        end
        f_rd_en = 0;
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL simul_left got %0d exp 0", q.size()); end
    endtask

    task automatic test_level();
        int exp_ram;
        for (int k = 1; k <= 8; k++) begin
            p_wr_en = 1; p_wr_data = 32'hC0DE_0000 + k;
            checks++; if (p_wr_vld !== 1'b1) begin errors++; $display("FAIL pass_wr_vld got %b exp 1", p_wr_vld); end
            @(negedge clk);
            exp_ram = (k == 1) ? 1 : k - 1;
            checks++; if (p_rd_vld !== (k >= 2)) begin errors++; $display("FAIL pass_latency k %0d got %b exp %b", k, p_rd_vld, (k >= 2)); end
`ifdef PCIE_FIFO_LEVEL_EN
            checks++; if (p_rd_level !== 5'(k)) begin errors++; $display("FAIL level k %0d got %0d exp %0d", k, p_rd_level, k); end
            checks++; if (p_wr_afull !== (exp_ram >= 6)) begin errors++; $display("FAIL afull k %0d got %b exp %b", k, p_wr_afull, (exp_ram >= 6)); end
`endif
        end
        p_wr_en = 0; p_rd_en = 1;
        for (int k = 1; k <= 8; k++) begin
            checks++; if (p_rd_data !== 32'hC0DE_0000 + k) begin errors++; $display("FAIL pass_data got %h exp %h", p_rd_data, 32'hC0DE_0000 + k); end
            @(negedge clk);
        end
        p_rd_en = 0;
        checks++; if (p_rd_vld !== 1'b0) begin errors++; $display("FAIL pass_empty got %b exp 0", p_rd_vld); end
`ifdef PCIE_FIFO_LEVEL_EN
        checks++; if (p_rd_level !== '0) begin errors++; $display("FAIL level_empty got %0d exp 0", p_rd_level); end
`endif
    endtask

    task automatic test_random_up();
        logic [15:0]  q[$];
        logic [127:0] exp;
        int sent = 0, got = 0, cyc = 0;
        while (got < 100 && cyc < 6000) begin
            u_wr_en = (sent < 800) && ($urandom_range(0, 3) != 0);
            u_wr_data = 16'($urandom);
            u_rd_en = 1'($urandom_range(0, 1));
            if (u_wr_en && u_wr_vld) begin q.push_back(u_wr_data); sent++; end
            if (u_rd_en && u_rd_vld) begin
                got++;
                checks++;
                if (q.size() < 8) begin
                    errors++; $display("FAIL rand_up_early got %0d queued exp 8", q.size());
                end else begin
                    for (int j = 0; j < 8; j++) exp[j*16 +: 16] = q[j];
                    repeat (8) void'(q.pop_front());
                    if (u_rd_data !== exp) begin errors++; $display("FAIL rand_up_data got %h exp %h", u_rd_data, exp); end
                end
            end
            @(negedge clk);
            cyc++;
        end
        u_wr_en = 0; u_rd_en = 0;
        checks++; if (got !== 100) begin errors++; $display("FAIL rand_up_timeout got %0d exp 100", got); end
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL rand_up_left got %0d exp 0", q.size()); end
    endtask

    task automatic test_random_down();
        logic [15:0] q[$];
        int sent = 0, got = 0, cyc = 0;
        while (got < 800 && cyc < 8000) begin
            d_wr_en = (sent < 100) && ($urandom_range(0, 3) == 0);
            d_wr_data = {$urandom, $urandom, $urandom, $urandom};
            d_rd_en = ($urandom_range(0, 3) != 0);
            if (d_wr_en && d_wr_vld) begin
                for (int j = 0; j < 8; j++) q.push_back(d_wr_data[j*16 +: 16]);
                sent++;
            end
            if (d_rd_en && d_rd_vld) begin
                got++;
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_dn_early got 0 queued exp 1");
                end else begin
                    if (d_rd_data !== q[0]) begin errors++; $display("FAIL rand_dn_data got %h exp %h", d_rd_data, q[0]); end
                    void'(q.pop_front());
                end
            end
            @(negedge clk);
            cyc++;
        end
        d_wr_en = 0; d_rd_en = 0;
        checks++; if (got !== 800) begin errors++; $display("FAIL rand_dn_timeout got %0d exp 800", got); end
        checks++; if (d_rd_vld !== 1'b0) begin errors++; $display("FAIL rand_dn_tail got %b exp 0", d_rd_vld); end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_unpack();
        test_full();
        test_reset_mid_pack();
        test_simultaneous();
        test_level();
        test_random_up();
        test_random_down();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
